// File: rtl/gf256_inv_iter.sv
// rtl/gf256_inv_iter.sv - iterative GF(2^8) inverter (y = x^254) with valid/ready handshakes
// Optional build macro GF_INV_UNROLL2_EN: two square-multiply steps per CALC cycle.
module gf256_inv_iter #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sq;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic [7:0] sq1;
  logic [7:0] acc1;
  logic       last;

  // Shift-and-add multiply; the running multiplicand is reduced every shift,
  // so no 15-bit product is ever formed.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = s[7] ? ({s[6:0], 1'b0} ^ POLY[7:0]) : {s[6:0], 1'b0};
    end
    return p;
  endfunction

  assign sq1  = gf_mul(sq, sq);
  assign acc1 = gf_mul(acc, sq1);

`ifdef GF_INV_UNROLL2_EN
  logic [7:0] sq2;
  logic [7:0] acc2;

  assign sq2  = gf_mul(sq1, sq1);
  assign acc2 = gf_mul(acc1, sq2);
  // Three double steps, then the lone seventh step on the fourth cycle.
  assign last = (cnt == 3'd3);
`else
  assign last = (cnt == 3'd6);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq       <= 8'h00;
      acc      <= 8'h00;
      cnt      <= 3'd0;
      out_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sq  <= in_data;
            acc <= 8'h01;
            cnt <= 3'd0;
          end
        end
        CALC: begin
          cnt <= cnt + 3'd1;
          if (last) out_data <= acc1;
`ifdef GF_INV_UNROLL2_EN
          if (!last) begin
            sq  <= sq2;
            acc <= acc2;
          end
`else
          sq  <= sq1;
          acc <= acc1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Held low while reset is asserted so no accept is advertised mid-reset.
  assign in_ready  = (state == IDLE) && reset_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gf256_inv_iter.sv
// tb/tb_gf256_inv_iter.sv - directed bench for gf256_inv_iter (honours GF_INV_UNROLL2_EN)
module tb_gf256_inv_iter;

`ifdef GF_INV_UNROLL2_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 7;
`endif
  localparam int SP = LAT + 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  gf256_inv_iter #(.POLY(9'h11B)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input logic [7:0] x, output logic [7:0] y, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    y = out_data;
  endtask

  initial begin
    logic [7:0] y;
    int         lat;
    int         results;
    int         accepts;
    int         prev;
    int         w;
    logic [7:0] xs [5];
    logic [7:0] ys [5];

    xs = '{8'h53, 8'h00, 8'h01, 8'h02, 8'hFF};
    ys = '{8'hCA, 8'h00, 8'h01, 8'h8D, 8'h1C};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed vectors, first one also checks latency
    for (int i = 0; i < 5; i++) begin
      run_vec(xs[i], y, lat);
      check($sformatf("vec_%02h", xs[i]), 32'(y), 32'(ys[i]));
      if (i == 0) check("latency", 32'(lat), 32'(LAT));
      @(posedge clk); #1;
      check("consumed_out_valid", 32'(out_valid), 32'd0);
    end

    // backpressure with ignored in_valid
    out_ready = 1'b0;
    run_vec(8'h02, y, lat);
    check("bp_first", 32'(y), 32'h8D);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h8D);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);

    // reset in the third CALC cycle
    in_valid = 1'b1;
    in_data  = 8'h53;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    run_vec(8'h53, y, lat);
    check("after_rst_53", 32'(y), 32'hCA);
    @(posedge clk); #1;

    // exhaustive sweep with random output stalls
    results = 0;
    out_ready = 1'b0;
    for (int x = 0; x < 256; x++) begin
      run_vec(8'(x), y, lat);
      if (out_valid) results++;
      if (x == 0) check("sweep_zero", 32'(y), 32'h00);
      else        check($sformatf("sweep_%02h", x), 32'(ref_mul(8'(x), y)), 32'h01);
      w = $urandom_range(0, 3);
      for (int s = 0; s < w; s++) begin
        @(posedge clk); #1;
        check("sweep_stall_data", 32'(out_data), 32'(y));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("sweep_count", 32'(results), 32'd256);

    // in_valid held high: one accept every SP cycles
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    accepts   = 0;
    prev      = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin
        if (prev < 0) check("b2b_first", 32'(i), 32'd0);
        else          check("b2b_spacing", 32'(i - prev), 32'(SP));
        prev = i;
        accepts++;
      end
    end
    check("b2b_accepts", 32'(accepts), 32'(29 / SP + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (busy && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("b2b_drained", 32'(busy), 32'd0);
    check("b2b_data", 32'(out_data), 32'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
